// File: rtl/onewire_slave.sv
// ============================================================================
//  Module      : onewire_slave
//  Description : 1-Wire bus slave. Detects bus reset and answers with a
//                presence pulse, samples write slots into a byte receiver and
//                drives read slots from a byte transmitter (LSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onewire_slave #(
    parameter int CW    = 16,
    parameter int T_RST = 1920,
    parameter int T_PDH = 120,
    parameter int T_PDL = 480,
    parameter int T_SMP = 120,
    parameter int T_RDL = 120
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        onewire,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       reset_det
);

    localparam logic [CW-1:0] c_smp      = CW'(T_SMP);
    localparam logic [CW-1:0] c_smp_last = CW'(T_SMP - 1);
    localparam logic [CW-1:0] c_rdl      = CW'(T_RDL);
    localparam logic [CW-1:0] c_rst_last = CW'(T_RST - 1);
    localparam logic [CW-1:0] c_pdh_last = CW'(T_PDH - 1);
    localparam logic [CW-1:0] c_pdl_last = CW'(T_PDL - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SLOT     = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_PD_WAIT  = 3'd3,
        ST_PD_LOW   = 3'd4,
        ST_PD_REL   = 3'd5
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [CW-1:0] r_cnt,       w_cnt_nxt;
    logic [2:0]    r_bit_cnt,   w_bit_cnt_nxt;
    logic          r_drive_low, w_drive_low_nxt;
    logic [7:0]    r_rx_sh,     w_rx_sh_nxt;
    logic [7:0]    r_tx_sh,     w_tx_sh_nxt;
    logic          r_tx_busy,   w_tx_busy_nxt;
    logic [7:0]    r_rx_data,   w_rx_data_nxt;
    logic          r_rx_valid,  w_rx_valid_nxt;
    logic          r_reset_det, w_reset_det_nxt;
    logic          r_tx_ready;
    logic          r_sync1, r_line_s, r_line_d;
    logic          w_fall, w_accept, w_first_bit, w_busy_eff;

    // Open-drain output: only ever pull low or release.
    assign onewire   = r_drive_low ? 1'b0 : 1'bz;
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign reset_det = r_reset_det;

    assign w_fall      = r_line_d & ~r_line_s;
    assign w_accept    = (r_state == ST_IDLE) & tx_valid & r_tx_ready;
    // A byte accepted in the same cycle as a falling edge drives its bit 0 at once.
    assign w_busy_eff  = r_tx_busy | w_accept;
    assign w_first_bit = w_accept ? tx_data[0] : r_tx_sh[0];

    // Bus synchroniser (idles high) plus one-cycle delay for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_line_s <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= onewire;
            r_line_s <= r_sync1;
            r_line_d <= r_line_s;
        end
    end

    // Next-state, slot timing, shift registers and output pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_drive_low_nxt = r_drive_low;
        w_rx_sh_nxt     = r_rx_sh;
        w_tx_sh_nxt     = r_tx_sh;
        w_tx_busy_nxt   = r_tx_busy;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_reset_det_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tx_sh_nxt   = tx_data;
                    w_tx_busy_nxt = 1'b1;
                end
                if (w_fall) begin
                    w_state_nxt = ST_SLOT;
                    w_cnt_nxt   = '0;
                    if (w_busy_eff && !w_first_bit) begin
                        w_drive_low_nxt = 1'b1;
                    end
                end
            end
            ST_SLOT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_smp_last) begin
                    w_rx_sh_nxt = {r_line_s, r_rx_sh[7:1]};
                    if (r_tx_busy) begin
                        w_tx_sh_nxt = {1'b0, r_tx_sh[7:1]};
                    end
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_data_nxt  = {r_line_s, r_rx_sh[7:1]};
                        w_rx_valid_nxt = 1'b1;
                        w_tx_busy_nxt  = 1'b0;
                    end
                end
                if (r_cnt == c_rdl) begin
                    w_drive_low_nxt = 1'b0;
                end
                if ((r_cnt >= c_smp) && r_line_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_line_s && (r_cnt == c_rst_last)) begin
                    w_state_nxt     = ST_RST_WAIT;
                    w_drive_low_nxt = 1'b0;
                end
            end
            ST_RST_WAIT: begin
                if (r_line_s) begin
                    w_reset_det_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_bit_cnt_nxt   = '0;
                    w_rx_sh_nxt     = '0;
                    w_tx_busy_nxt   = 1'b0;
                    w_state_nxt     = ST_PD_WAIT;
                end
            end
            ST_PD_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_pdh_last) begin
                    w_drive_low_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_PD_LOW;
                end
            end
            ST_PD_LOW: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_pdl_last) begin
                    w_drive_low_nxt = 1'b0;
                    w_state_nxt     = ST_PD_REL;
                end
            end
            ST_PD_REL: begin
                // The master may still be holding the bus; ignore edges until it is high.
                if (r_line_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_drive_low_nxt = 1'b0;
            end
        endcase
    end

    // State register; tx_ready is registered so it rises the cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_drive_low <= 1'b0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_tx_busy   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_reset_det <= 1'b0;
            r_tx_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_drive_low <= w_drive_low_nxt;
            r_rx_sh     <= w_rx_sh_nxt;
            r_tx_sh     <= w_tx_sh_nxt;
            r_tx_busy   <= w_tx_busy_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_reset_det <= w_reset_det_nxt;
            r_tx_ready  <= (w_state_nxt == ST_IDLE) && !w_tx_busy_nxt && (w_bit_cnt_nxt == 3'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_onewire_slave.sv
// ============================================================================
//  Module      : tb_onewire_slave
//  Description : Self-checking bench for onewire_slave. A behavioural 1-Wire
//                master drives reset, write and read slots; expected values
//                come from byte/bit arithmetic on the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onewire_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       master_low;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reset_det;
    wire        onewire;

    int         checks = 0;
    int         errors = 0;
    int         rxv_cnt = 0;
    int         det_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    assign onewire = master_low ? 1'b0 : 1'bz;
    pullup (onewire);

    always #5 clk = ~clk;

    onewire_slave dut (
        .clk       (clk),
        .rst       (rst),
        .onewire   (onewire),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reset_det (reset_det)
    );

    // Event monitor: count received bytes and reset detections.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt <= rxv_cnt + 1;
            rx_last <= rx_data;
        end
        if (reset_det === 1'b1) det_cnt <= det_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One master slot: pull low for low_cyc cycles, total slot length total.
    task automatic slot(input int low_cyc, input int total, output logic smp, output int low_n);
        low_n = 0;
        smp   = 1'b1;
        master_low = 1'b1;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (onewire === 1'b0) low_n++;
            if (i == 60) smp = onewire;
            if (i == low_cyc) master_low = 1'b0;
        end
    endtask

    task automatic write_bit(input logic b);
        logic s;
        int   n;
        slot(b ? 24 : 240, 280, s, n);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
        repeat (5) @(negedge clk);
    endtask

    // Read one byte and check each bit plus the slave's hold-low time on zeros.
    task automatic read_byte(input logic [7:0] v);
        logic s;
        int   n;
        for (int i = 0; i < 8; i++) begin
            slot(8, 280, s, n);
            check("rd_bit", s, v[i]);
            if (v[i]) check("rd1_low_len", n, 8);
            else      check("rd0_low_30us", (n >= 115 && n <= 130), 1);
        end
    endtask

    task automatic offer_tx(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        check("tx_ready_idle", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_busy", tx_ready, 0);
    endtask

    // Bus reset: hold low 2000 cycles, release, watch 800 cycles.
    task automatic bus_reset(output int det_at, output int det_n, output int lo, output int hi);
        det_at = -1; det_n = 0; lo = -1; hi = -1;
        master_low = 1'b1;
        repeat (2000) @(negedge clk);
        master_low = 1'b0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (reset_det === 1'b1) begin det_n++; det_at = i; end
            if (onewire === 1'b0 && lo < 0) lo = i;
            if (onewire === 1'b1 && lo >= 0 && hi < 0) hi = i;
        end
    endtask

    initial begin : stim
        int         det_at, det_n, lo, hi, rx0, det0, n;
        logic       s;
        logic [7:0] rb;
        logic [6:0] b7;

        rst = 1'b1; master_low = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_reset_det", reset_det, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_line_released", onewire, 1);
        rst = 1'b0;
        @(negedge clk);
        check("tx_ready_after_rst", tx_ready, 1);

        // 1: bus reset and presence pulse
        bus_reset(det_at, det_n, lo, hi);
        check("reset_det_count", det_n, 1);
        check("reset_det_latency", det_at, 3);
        check("pd_start_window", (lo >= 117 && lo <= 123), 1);
        check("pd_end_window", (hi >= 597 && hi <= 603), 1);
        check("no_rx_on_reset", rxv_cnt, 0);

        // 2: write bytes
        rx0 = rxv_cnt;
        write_byte(8'hA5);
        check("wr_a5_count", rxv_cnt - rx0, 1);
        check("wr_a5_data", rx_last, 8'hA5);
        rb = 8'($urandom);
        rx0 = rxv_cnt;
        write_byte(rb);
        check("wr_rand_count", rxv_cnt - rx0, 1);
        check("wr_rand_data", rx_last, rb);

        // 3: read bytes
        rx0 = rxv_cnt;
        offer_tx(8'h3C);
        read_byte(8'h3C);
        repeat (5) @(negedge clk);
        check("rd_3c_count", rxv_cnt - rx0, 1);
        check("rd_3c_echo", rx_last, 8'h3C);
        check("rd_3c_tx_ready", tx_ready, 1);
        rb = 8'($urandom);
        rx0 = rxv_cnt;
        offer_tx(rb);
        read_byte(rb);
        repeat (5) @(negedge clk);
        check("rd_rand_echo", rx_last, rb);
        check("rd_rand_tx_ready", tx_ready, 1);

        // 4: bus reset in the middle of a transmit
        offer_tx(8'hFF);
        for (int i = 0; i < 3; i++) begin
            slot(8, 280, s, n);
            check("rd_ff_bit", s, 1);
        end
        rx0 = rxv_cnt;
        bus_reset(det_at, det_n, lo, hi);
        check("midtx_reset_det", det_n, 1);
        check("midtx_no_rx", rxv_cnt - rx0, 0);
        check("midtx_tx_ready", tx_ready, 1);
        write_byte(8'h12);
        check("midtx_wr_count", rxv_cnt - rx0, 1);
        check("midtx_wr_data", rx_last, 8'h12);

        // 5: long low just below reset threshold is a write '0'
        rx0 = rxv_cnt;
        det0 = det_cnt;
        slot(1600, 1700, s, n);
        check("long0_no_reset", det_cnt - det0, 0);
        check("long0_bit_pending", tx_ready, 0);
        b7 = 7'($urandom);
        for (int i = 0; i < 7; i++) write_bit(b7[i]);
        repeat (5) @(negedge clk);
        check("long0_count", rxv_cnt - rx0, 1);
        check("long0_data", rx_last, {b7, 1'b0});

        // 6: rst pulse while presence is being driven
        master_low = 1'b1;
        repeat (2000) @(negedge clk);
        master_low = 1'b0;
        repeat (300) @(negedge clk);
        check("pd_low_active", onewire, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst6_line_released", onewire, 1);
        check("rst6_rx_data", rx_data, 8'h00);
        check("rst6_rx_valid", rx_valid, 0);
        check("rst6_reset_det", reset_det, 0);
        check("rst6_tx_ready", tx_ready, 0);
        @(negedge clk);
        check("rst6_tx_ready_idle", tx_ready, 1);
        rb = 8'($urandom);
        rx0 = rxv_cnt;
        write_byte(rb);
        check("rst6_wr_count", rxv_cnt - rx0, 1);
        check("rst6_wr_data", rx_last, rb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
